// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcodes, ALU/SP op codes,
// state encoding and the packed control vector driven onto the datapath.
package multicycle_control_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00001;
    localparam logic [4:0] OP_LD    = 5'b00010;
    localparam logic [4:0] OP_ST    = 5'b00011;
    localparam logic [4:0] OP_BZ    = 5'b00100;
    localparam logic [4:0] OP_BNZ   = 5'b00101;
    localparam logic [4:0] OP_J     = 5'b00110;
    localparam logic [4:0] OP_CALL  = 5'b00111;
    localparam logic [4:0] OP_RET   = 5'b01000;
    localparam logic [4:0] OP_PUSH  = 5'b01001;
    localparam logic [4:0] OP_POP   = 5'b01010;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] SP_ADD  = 4'd0;
    localparam logic [3:0] SP_SUB  = 4'd1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JMP, S_STK_MEM, S_STK_UPD, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       jump;
        logic       b_and_z;
        logic       pc_op;
        logic       addr_op;
        logic       a_op2;
        logic       write_data_op;
        logic       wd_op2;
        logic       mem_read;
        logic       mem_write;
        logic       sp_write;
        logic [3:0] alu_op;
        logic [3:0] sp_op;
        logic       halted;
    } ctrl_t;

    function automatic logic is_defined(input logic [4:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_LD, OP_ST, OP_BZ, OP_BNZ, OP_J,
            OP_CALL, OP_RET, OP_PUSH, OP_POP, OP_HALT: is_defined = 1'b1;
            default:                                   is_defined = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational decoder: current state plus latched opcode/funct to the full
// datapath control vector. Anything not asserted here stays 0.
module ctrl_decode
    import multicycle_control_pkg::*;
#(
    parameter int OPW = 5,
    parameter int FNW = 4
) (
    input  state_t         state,
    input  logic [OPW-1:0] opc,
    input  logic [FNW-1:0] fn,
    input  logic           zero,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src = !(opc == OP_RTYPE || opc == OP_BZ || opc == OP_BNZ);
                if (opc == OP_RTYPE)
                    ctrl.alu_op = fn;
                else if (opc == OP_BZ || opc == OP_BNZ)
                    ctrl.alu_op = ALU_SUB;
                else
                    ctrl.alu_op = ALU_ADD;
                // Branch condition is resolved here and committed straight to the PC.
                if (opc == OP_BZ) begin
                    ctrl.b_and_z  = zero;
                    ctrl.pc_write = 1'b1;
                end else if (opc == OP_BNZ) begin
                    ctrl.b_and_z  = !zero;
                    ctrl.pc_write = 1'b1;
                end
            end
            S_MEM: begin
                ctrl.mem_read  = (opc == OP_LD);
                ctrl.mem_write = (opc == OP_ST);
            end
            S_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = (opc == OP_LD);
                ctrl.reg_dst    = (opc == OP_RTYPE);
            end
            S_JMP: begin
                ctrl.jump     = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            S_STK_MEM: begin
                ctrl.addr_op = 1'b1;
                case (opc)
                    OP_PUSH: begin
                        ctrl.sp_op     = SP_SUB;
                        ctrl.mem_write = 1'b1;
                    end
                    OP_CALL: begin
                        // Pushes the return PC rather than a register value.
                        ctrl.sp_op         = SP_SUB;
                        ctrl.mem_write     = 1'b1;
                        ctrl.write_data_op = 1'b1;
                    end
                    OP_POP, OP_RET: begin
                        ctrl.sp_op    = SP_ADD;
                        ctrl.a_op2    = 1'b1;
                        ctrl.mem_read = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_STK_UPD: begin
                ctrl.sp_write = 1'b1;
                case (opc)
                    OP_CALL: begin
                        ctrl.jump     = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end
                    OP_RET: begin
                        ctrl.pc_op    = 1'b1;
                        ctrl.pc_write = 1'b1;
                    end
                    OP_POP: begin
                        ctrl.reg_write  = 1'b1;
                        ctrl.mem_to_reg = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and
// stack operations, with a bounded memory handshake that halts on timeout.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPW     = 5,
    parameter int FNW     = 4,
    parameter int MAXWAIT = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic [FNW-1:0] funct,
    input  logic           zero,
    input  logic           memReady,
    output logic           pcWrite,
    output logic           irWrite,
    output logic           regWrite,
    output logic           regDst,
    output logic           aluSrc,
    output logic           memToReg,
    output logic           jump,
    output logic           bAndZ,
    output logic           pcOp,
    output logic           addrOp,
    output logic           aOp2,
    output logic           writeDataOp,
    output logic           wdOp2,
    output logic           memRead,
    output logic           memWrite,
    output logic           spWrite,
    output logic [3:0]     aluOp,
    output logic [3:0]     spOp,
    output logic           halted,
    output logic           illegal
);

    localparam int WCW = $clog2(MAXWAIT + 1);

    state_t         state, state_nx;
    logic [OPW-1:0] opc;
    logic [FNW-1:0] fn;
    logic [WCW-1:0] waitcnt;
    logic           illegal_r;
    logic           mem_state, mem_enter, timeout;
    ctrl_t          ctrl, ctrl_gated;

    assign mem_state = (state == S_MEM) || (state == S_STK_MEM);
    assign mem_enter = ((state_nx == S_MEM) || (state_nx == S_STK_MEM)) && !mem_state;
    assign timeout   = mem_state && !memReady && (waitcnt == WCW'(MAXWAIT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI, OP_LD, OP_ST, OP_BZ, OP_BNZ: state_nx = S_EXEC;
                    OP_J:                                  state_nx = S_JMP;
                    OP_PUSH, OP_CALL, OP_POP, OP_RET:      state_nx = S_STK_MEM;
                    OP_HALT:                               state_nx = S_HALT;
                    default:                               state_nx = S_FETCH;
                endcase
            end
            S_EXEC: begin
                if (opc == OP_LD || opc == OP_ST)
                    state_nx = S_MEM;
                else if (opc == OP_RTYPE || opc == OP_ADDI)
                    state_nx = S_WB;
                else
                    state_nx = S_FETCH;
            end
            S_MEM: begin
                if (memReady)
                    state_nx = (opc == OP_LD) ? S_WB : S_FETCH;
                else if (timeout)
                    state_nx = S_HALT;
            end
            S_STK_MEM: begin
                if (memReady)
                    state_nx = S_STK_UPD;
                else if (timeout)
                    state_nx = S_HALT;
            end
            S_WB, S_JMP, S_STK_UPD: state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            opc       <= '0;
            fn        <= '0;
            waitcnt   <= '0;
            illegal_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE) begin
                opc <= opcode;
                fn  <= funct;
                if (!is_defined(opcode))
                    illegal_r <= 1'b1;
            end
            if (mem_enter)
                waitcnt <= '0;
            else if (mem_state && !memReady)
                waitcnt <= waitcnt + WCW'(1);
            if (timeout)
                illegal_r <= 1'b1;
        end
    end

    ctrl_decode #(.OPW(OPW), .FNW(FNW)) u_decode (
        .state (state),
        .opc   (opc),
        .fn    (fn),
        .zero  (zero),
        .ctrl  (ctrl)
    );

    // Reset masks the whole vector immediately so an in-flight access drops its strobes.
    assign ctrl_gated  = reset ? '0 : ctrl;

    assign pcWrite     = ctrl_gated.pc_write;
    assign irWrite     = ctrl_gated.ir_write;
    assign regWrite    = ctrl_gated.reg_write;
    assign regDst      = ctrl_gated.reg_dst;
    assign aluSrc      = ctrl_gated.alu_src;
    assign memToReg    = ctrl_gated.mem_to_reg;
    assign jump        = ctrl_gated.jump;
    assign bAndZ       = ctrl_gated.b_and_z;
    assign pcOp        = ctrl_gated.pc_op;
    assign addrOp      = ctrl_gated.addr_op;
    assign aOp2        = ctrl_gated.a_op2;
    assign writeDataOp = ctrl_gated.write_data_op;
    assign wdOp2       = ctrl_gated.wd_op2;
    assign memRead     = ctrl_gated.mem_read;
    assign memWrite    = ctrl_gated.mem_write;
    assign spWrite     = ctrl_gated.sp_write;
    assign aluOp       = ctrl_gated.alu_op;
    assign spOp        = ctrl_gated.sp_op;
    assign halted      = ctrl_gated.halted;
    assign illegal     = !reset && illegal_r;

endmodule
